// File: rtl/peripheral_uart_pkg.sv
// Shared types and constants for the parametrised UART transmitter.
package peripheral_uart_pkg;

    localparam logic [2:0] TstIdle   = 3'd0;
    localparam logic [2:0] TstLoad   = 3'd1;
    localparam logic [2:0] TstStart  = 3'd2;
    localparam logic [2:0] TstData   = 3'd3;
    localparam logic [2:0] TstParity = 3'd4;
    localparam logic [2:0] TstStop   = 3'd5;

    typedef enum logic [2:0] {
        StIdle   = TstIdle,
        StLoad   = TstLoad,
        StStart  = TstStart,
        StData   = TstData,
        StParity = TstParity,
        StStop   = TstStop
    } tx_state_e;

    // Parity modes indexed by {ep, sp}
    localparam logic [1:0] ParOdd   = 2'b00;
    localparam logic [1:0] ParEven  = 2'b10;
    localparam logic [1:0] ParMark  = 2'b01;
    localparam logic [1:0] ParSpace = 2'b11;

    typedef struct packed {
        logic [3:0] len;
        logic       pe;
        logic       ep;
        logic       sp;
        logic       stb;
    } uart_tx_cfg_t;

    function automatic logic [3:0] word_len(input logic [1:0] sel, input int unsigned max_w);
        int unsigned w;
        w = 32'd5 + 32'(sel);
        if (w > max_w) w = max_w;
        return 4'(w);
    endfunction

    function automatic logic parity_out(input logic [1:0] mode, input logic p);
        case (mode)
            ParOdd:  return ~p;
            ParEven: return p;
            ParMark: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/peripheral_uart_sync_fifo_wb.sv
// Synchronous FIFO with full-width occupancy count and a one-cycle clear.
module peripheral_uart_sync_fifo_wb #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CntW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr) begin
            // Clear wins over any same-cycle push or pop
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/peripheral_uart_transmitter_param_wb.sv
// UART transmitter: FIFO-fed start/data/parity/stop serialiser with CTS, break and status flags.
module peripheral_uart_transmitter_param_wb
    import peripheral_uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned TX_THRESH  = 2,
    parameter int unsigned MSB_FIRST  = 0
) (
    input  logic                          clk,
    input  logic                          wb_rst_ni,
    input  logic                          baud_tick,
    input  logic [1:0]                    cfg_len,
    input  logic                          cfg_pe,
    input  logic                          cfg_ep,
    input  logic                          cfg_sp,
    input  logic                          cfg_stb,
    input  logic                          cfg_brk,
    input  logic                          cfg_cts_en,
    input  logic                          cts_n,
    input  logic                          s_valid,
    input  logic [DATA_W-1:0]             s_data,
    output logic                          s_ready,
    input  logic                          fifo_clr,
    output logic                          txd,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          tx_empty,
    output logic                          thr_irq,
    output logic [2:0]                    tstate
);
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TickW = $clog2(2 * OVERSAMPLE);
    localparam logic [TickW-1:0] TickBit    = TickW'(OVERSAMPLE - 1);
    localparam logic [TickW-1:0] TickStop15 = TickW'(3 * OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] TickStop2  = TickW'(2 * OVERSAMPLE - 1);

    tx_state_e         state_q, state_d;
    logic [TickW-1:0]  tick_q, tick_d, tick_limit;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    uart_tx_cfg_t      cfg_q, cfg_d;
    logic              txd_q, txd_d;
    logic              tx_empty_q, thr_irq_q;

    logic [DATA_W-1:0] fifo_rdata, masked, full_rev, rev;
    logic [CntW-1:0]   fifo_cnt;
    logic              fifo_full, fifo_empty, fifo_pop, tick_end;
    logic [3:0]        cur_len;

    peripheral_uart_sync_fifo_wb #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (wb_rst_ni),
        .push  (s_valid),
        .pop   (fifo_pop),
        .clr   (fifo_clr),
        .wdata (s_data),
        .rdata (fifo_rdata),
        .count (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cur_len = word_len(cfg_len, DATA_W);

    // MSB-first words are bit-reversed at load so the shifter always emits bit 0
    always_comb begin
        masked = fifo_rdata & ~({DATA_W{1'b1}} << cur_len);
        for (int i = 0; i < DATA_W; i++) full_rev[i] = masked[DATA_W-1-i];
        rev = full_rev >> (4'(DATA_W) - cur_len);
    end

    always_comb begin
        case (state_q)
            StStop:  tick_limit = !cfg_q.stb ? TickBit :
                                  (cfg_q.len == 4'd5) ? TickStop15 : TickStop2;
            default: tick_limit = TickBit;
        endcase
        tick_end = baud_tick && (tick_q == tick_limit);
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        cfg_d     = cfg_q;
        fifo_pop  = 1'b0;
        if (baud_tick && state_q inside {StStart, StData, StParity, StStop}) begin
            tick_d = tick_end ? '0 : tick_q + TickW'(1);
        end
        case (state_q)
            StIdle: begin
                tick_d = '0;
                if (!fifo_empty && (!cfg_cts_en || !cts_n)) state_d = StLoad;
            end
            StLoad: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    cfg_d     = '{len: cur_len, pe: cfg_pe, ep: cfg_ep, sp: cfg_sp, stb: cfg_stb};
                    shift_d   = (MSB_FIRST != 0) ? rev : masked;
                    bit_cnt_d = cur_len;
                    parity_d  = ^masked;
                    state_d   = StStart;
                end else begin
                    // Flushed between the IDLE check and the pop
                    state_d = StIdle;
                end
            end
            StStart: if (tick_end) state_d = StData;
            StData: begin
                if (tick_end) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q - 4'd1;
                    if (bit_cnt_q == 4'd1) state_d = cfg_q.pe ? StParity : StStop;
                end
            end
            StParity: if (tick_end) state_d = StStop;
            StStop:   if (tick_end) state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        case (state_d)
            StStart:  txd_d = 1'b0;
            StData:   txd_d = shift_d[0];
            StParity: txd_d = parity_out({cfg_q.ep, cfg_q.sp}, parity_q);
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= StIdle;
            tick_q     <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            cfg_q      <= '0;
            txd_q      <= 1'b1;
            tx_empty_q <= 1'b1;
            thr_irq_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            cfg_q      <= cfg_d;
            txd_q      <= txd_d;
            tx_empty_q <= fifo_empty && (state_q == StIdle);
            thr_irq_q  <= (fifo_cnt <= CntW'(TX_THRESH));
        end
    end

    assign txd        = cfg_brk ? 1'b0 : txd_q;
    assign s_ready    = !fifo_full;
    assign fifo_count = fifo_cnt;
    assign busy       = (state_q != StIdle);
    assign tx_empty   = tx_empty_q;
    assign thr_irq    = thr_irq_q;
    assign tstate     = state_q;

endmodule

// File: tb/tb_peripheral_uart_transmitter_param_wb.sv
// Directed bench: frame vectors on LSB- and MSB-first instances plus CTS, flush, break, reset.
module tb_peripheral_uart_transmitter_param_wb;

    logic       clk = 1'b0;
    logic       wb_rst_ni, baud_tick;
    logic [1:0] cfg_len;
    logic       cfg_pe, cfg_ep, cfg_sp, cfg_stb, cfg_brk, cfg_cts_en, cts_n;
    logic       s_valid, fifo_clr;
    logic [7:0] s_data;

    logic       s_ready, txd, busy, tx_empty, thr_irq;
    logic [4:0] fifo_count;
    logic [2:0] tstate;
    logic       s_ready_m, txd_m, busy_m, tx_empty_m, thr_irq_m;
    logic [4:0] fifo_count_m;
    logic [2:0] tstate_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    peripheral_uart_transmitter_param_wb dut (
        .clk(clk), .wb_rst_ni(wb_rst_ni), .baud_tick(baud_tick), .cfg_len(cfg_len),
        .cfg_pe(cfg_pe), .cfg_ep(cfg_ep), .cfg_sp(cfg_sp), .cfg_stb(cfg_stb),
        .cfg_brk(cfg_brk), .cfg_cts_en(cfg_cts_en), .cts_n(cts_n), .s_valid(s_valid),
        .s_data(s_data), .s_ready(s_ready), .fifo_clr(fifo_clr), .txd(txd),
        .fifo_count(fifo_count), .busy(busy), .tx_empty(tx_empty), .thr_irq(thr_irq),
        .tstate(tstate)
    );

    peripheral_uart_transmitter_param_wb #(.MSB_FIRST(1)) dut_msb (
        .clk(clk), .wb_rst_ni(wb_rst_ni), .baud_tick(baud_tick), .cfg_len(cfg_len),
        .cfg_pe(cfg_pe), .cfg_ep(cfg_ep), .cfg_sp(cfg_sp), .cfg_stb(cfg_stb),
        .cfg_brk(cfg_brk), .cfg_cts_en(cfg_cts_en), .cts_n(cts_n), .s_valid(s_valid),
        .s_data(s_data), .s_ready(s_ready_m), .fifo_clr(fifo_clr), .txd(txd_m),
        .fifo_count(fifo_count_m), .busy(busy_m), .tx_empty(tx_empty_m), .thr_irq(thr_irq_m),
        .tstate(tstate_m)
    );

    typedef struct {
        logic [1:0] len_sel;
        logic       pe, ep, sp, stb;
        logic [7:0] data;
        int         nd;
        logic       exp_par;
        int         exp_stop;
        int         exp_frame;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_cfg(input logic [1:0] l, input logic pe, input logic ep, input logic sp,
                           input logic stb);
        cfg_len = l; cfg_pe = pe; cfg_ep = ep; cfg_sp = sp; cfg_stb = stb;
    endtask

    task automatic wait_start(input string name);
        int lat = 0;
        while (txd !== 1'b0 && lat < 10) begin step(); lat++; end
        check({name, " latency"}, lat, 2);
    endtask

    task automatic run_frame(input int idx);
        vec_t v;
        logic samp[12];
        logic samp_m[12];
        int t, stop_n, nb;
        v = vecs[idx];
        set_cfg(v.len_sel, v.pe, v.ep, v.sp, v.stb);
        s_data = v.data; s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        check($sformatf("v%0d count after push", idx), fifo_count, 1);
        wait_start($sformatf("v%0d", idx));
        nb = 2 + v.nd + int'(v.pe);
        t = 0; stop_n = 0;
        while (tstate != 3'd0 && t < 400) begin
            if (t % 16 == 8 && t / 16 < nb) begin samp[t/16] = txd; samp_m[t/16] = txd_m; end
            if (tstate == 3'd5) stop_n++;
            step(); t++;
        end
        check($sformatf("v%0d start", idx), samp[0], 0);
        check($sformatf("v%0d msb start", idx), samp_m[0], 0);
        for (int k = 0; k < v.nd; k++) begin
            check($sformatf("v%0d data%0d", idx, k), samp[1+k], v.data[k]);
            check($sformatf("v%0d msb data%0d", idx, k), samp_m[1+k], v.data[v.nd-1-k]);
        end
        if (v.pe) begin
            check($sformatf("v%0d parity", idx), samp[1+v.nd], v.exp_par);
            check($sformatf("v%0d msb parity", idx), samp_m[1+v.nd], v.exp_par);
        end
        check($sformatf("v%0d stop bit", idx), samp[nb-1], 1);
        check($sformatf("v%0d stop clk", idx), stop_n, v.exp_stop);
        check($sformatf("v%0d frame clk", idx), t, v.exp_frame);
        step();
        check($sformatf("v%0d tx_empty", idx), tx_empty, 1);
        check($sformatf("v%0d busy", idx), busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t;
        logic bad;
        logic [2:0] st_rel;

        //            len   pe    ep    sp    stb   data   nd par stop frame
        vecs[0] = '{2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 8, 1'b0, 16, 160};
        vecs[1] = '{2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h41, 7, 1'b0, 16, 160};
        vecs[2] = '{2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h41, 7, 1'b1, 16, 160};
        vecs[3] = '{2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 8'h41, 7, 1'b0, 16, 160};
        vecs[4] = '{2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'h41, 7, 1'b1, 16, 160};
        vecs[5] = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h13, 5, 1'b0, 24, 120};
        vecs[6] = '{2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA3, 8, 1'b0, 32, 176};
        vecs[7] = '{2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 6, 1'b0, 16, 144};
        vecs[8] = '{2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 8, 1'b0, 16, 160};
        vecs[9] = '{2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 8, 1'b0, 32, 192};

        wb_rst_ni = 1'b0; baud_tick = 1'b1; cfg_brk = 1'b0; cfg_cts_en = 1'b0; cts_n = 1'b1;
        s_valid = 1'b0; s_data = '0; fifo_clr = 1'b0;
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); step();
        check("rst txd", txd, 1);
        check("rst tstate", tstate, 0);
        check("rst count", fifo_count, 0);
        check("rst s_ready", s_ready, 1);
        check("rst busy", busy, 0);
        check("rst tx_empty", tx_empty, 1);
        check("rst thr_irq", thr_irq, 1);
        wb_rst_ni = 1'b1;
        step(); step();

        for (int i = 0; i < 10; i++) run_frame(i);

        // Break mid-frame: line held low, FSM timing unaffected
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        s_data = 8'h55; s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        wait_start("brk");
        t = 0; bad = 1'b0; st_rel = '0;
        while (tstate != 3'd0 && t < 400) begin
            if (t == 20) cfg_brk = 1'b1;
            if (t > 20 && t < 100 && txd !== 1'b0) bad = 1'b1;
            if (t == 100) begin st_rel = tstate; cfg_brk = 1'b0; end
            if (t == 120) check("brk txd after release", txd, 1);
            step(); t++;
        end
        check("brk txd held low", bad, 0);
        check("brk tstate at release", st_rel, 3);
        check("brk frame clk", t, 160);
        step();

        // CTS stall: fill FIFO, nothing transmits
        cfg_cts_en = 1'b1; cts_n = 1'b1; bad = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            s_data = 8'(i);
            step();
            if (txd !== 1'b1 || tstate != 3'd0) bad = 1'b1;
        end
        s_valid = 1'b0;
        check("cts count", fifo_count, 16);
        check("cts msb count", fifo_count_m, 16);
        check("cts s_ready", s_ready, 0);
        check("cts idle", bad, 0);
        check("cts thr_irq", thr_irq, 0);
        check("cts tx_empty", tx_empty, 0);
        cts_n = 1'b0;
        step();
        check("cts release load", tstate, 1);
        step();
        check("cts release start", tstate, 2);
        check("cts release count", fifo_count, 15);
        cts_n = 1'b1;
        t = 0;
        for (int i = 0; i < 20; i++) begin step(); t++; end
        // Flush with a colliding push: clear wins
        fifo_clr = 1'b1; s_valid = 1'b1; s_data = 8'hAA;
        step(); t++;
        fifo_clr = 1'b0; s_valid = 1'b0;
        check("clr count", fifo_count, 0);
        check("clr s_ready", s_ready, 1);
        while (tstate != 3'd0 && t < 400) begin step(); t++; end
        check("clr frame completes", t, 160);
        step(); step(); step();
        check("clr stays idle", tstate, 0);
        check("clr count after", fifo_count, 0);
        check("clr tx_empty", tx_empty, 1);
        check("clr thr_irq", thr_irq, 1);
        cfg_cts_en = 1'b0;

        // Async reset mid-DATA with words queued
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin s_data = 8'h0F; step(); end
        s_valid = 1'b0;
        t = 0;
        while (tstate != 3'd3 && t < 50) begin step(); t++; end
        check("rst reached data", tstate, 3);
        step(); step(); step(); step(); step();
        wb_rst_ni = 1'b0;
        #1;
        check("midrst txd", txd, 1);
        check("midrst count", fifo_count, 0);
        check("midrst tstate", tstate, 0);
        step();
        wb_rst_ni = 1'b1;
        step(); step(); step();
        check("postrst tstate", tstate, 0);
        check("postrst txd", txd, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
